// File: rtl/axi_rd_burst_tracker.sv
// Read-burst bookkeeping FIFO: records ARLEN per accepted AR, counts R beats of the head burst.
// Optional protocol checking (early/missing RLAST, resync on ARLEN count) under `BURST_TRK_CHK_EN.
module axi_rd_burst_tracker #(
  parameter int LEN_W     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ar_valid,
  input  logic                 ar_ready,
  input  logic [LEN_W-1:0]     ar_len,
  input  logic                 r_valid,
  input  logic                 r_ready,
  input  logic                 r_last,
  output logic                 full_n,
  output logic                 empty_n,
  output logic [DEPTH_LOG:0]   level,
  output logic [LEN_W-1:0]     head_len,
  output logic [LEN_W-1:0]     beat_cnt,
  output logic                 exp_last,
  output logic [3:0]           err,
  input  logic                 err_clr
);

  localparam int DEPTH = 2 ** DEPTH_LOG;

  logic [LEN_W-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG:0] wp_q, wp_d, rp_q, rp_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [3:0]         err_q, err_d, err_set;

  logic push, beat, full, empty, beat_ok, pop, push_acc, head_done;

  assign push  = ar_valid && ar_ready;
  assign beat  = r_valid && r_ready;
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[DEPTH_LOG-1:0] == rp_q[DEPTH_LOG-1:0]) &&
                 (wp_q[DEPTH_LOG] != rp_q[DEPTH_LOG]);

  assign head_len  = mem_q[rp_q[DEPTH_LOG-1:0]];
  assign head_done = (beat_q == head_len);
  // A beat that coincides with a push into an empty FIFO still counts as a beat-while-empty.
  assign beat_ok   = beat && !empty;

`ifdef BURST_TRK_CHK_EN
  assign pop = beat_ok && (r_last || head_done);
`else
  assign pop = beat_ok && r_last;
`endif

  assign push_acc = push && (!full || pop);

  always_comb begin
    err_set    = '0;
    err_set[3] = push && full && !pop;
    err_set[2] = beat && empty;
`ifdef BURST_TRK_CHK_EN
    err_set[0] = beat_ok && r_last && (beat_q < head_len);
    err_set[1] = beat_ok && !r_last && head_done;
`endif
  end

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    beat_d = beat_q;
    err_d  = err_clr ? '0 : (err_q | err_set);
    if (push_acc) wp_d = wp_q + 1'b1;
    if (pop) begin
      rp_d   = rp_q + 1'b1;
      beat_d = '0;
    end else if (beat_ok) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      beat_q <= '0;
      err_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      beat_q <= beat_d;
      err_q  <= err_d;
      if (push_acc) mem_q[wp_q[DEPTH_LOG-1:0]] <= ar_len;
    end
  end

  assign full_n   = !full;
  assign empty_n  = !empty;
  assign level    = wp_q - rp_q;
  assign beat_cnt = beat_q;
  assign exp_last = !empty && head_done;
  assign err      = err_q;

endmodule

// File: tb/tb_axi_rd_burst_tracker.sv
// Scoreboard bench for axi_rd_burst_tracker: directed steps queue expected state, negedge monitor checks it.
module tb_axi_rd_burst_tracker;

  typedef struct packed {
    logic       full_n;
    logic       empty_n;
    logic [3:0] level;
    logic [7:0] head_len;
    logic [7:0] beat_cnt;
    logic       exp_last;
    logic [3:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ar_valid, ar_ready, r_valid, r_ready, r_last, err_clr;
  logic [7:0] ar_len;
  logic       full_n, empty_n, exp_last;
  logic [3:0] level, err;
  logic [7:0] head_len, beat_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t  exp_q[$];
  string nm_q[$];

  axi_rd_burst_tracker #(.LEN_W(8), .DEPTH_LOG(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .full_n(full_n), .empty_n(empty_n), .level(level),
    .head_len(head_len), .beat_cnt(beat_cnt), .exp_last(exp_last),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(input logic fn, en, input int lv, hd, bc, input logic el, input int er);
    exp_t e;
    e.full_n = fn; e.empty_n = en; e.level = lv[3:0]; e.head_len = hd[7:0];
    e.beat_cnt = bc[7:0]; e.exp_last = el; e.err = er[3:0];
    return e;
  endfunction

  // Drive one cycle of inputs, then queue the state expected after that clock edge.
  task automatic step(input logic rn, av, ar, input int len, input logic rv, rr, rl, clr,
                      input exp_t e, input string nm);
    rst_n = rn; ar_valid = av; ar_ready = ar; ar_len = len[7:0];
    r_valid = rv; r_ready = rr; r_last = rl; err_clr = clr;
    @(posedge clk); #1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    rst_n = 1'b1; ar_valid = 1'b0; ar_ready = 1'b0; r_valid = 1'b0; r_ready = 1'b0;
    r_last = 1'b0; err_clr = 1'b0;
  endtask

  task automatic push(input int len, input exp_t e, input string nm);
    step(1, 1, 1, len, 0, 0, 0, 0, e, nm);
  endtask

  task automatic rbeat(input logic last, input exp_t e, input string nm);
    step(1, 0, 0, 0, 1, 1, last, 0, e, nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      a  = '{full_n, empty_n, level, head_len, beat_cnt, exp_last, err};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got full_n=%0b empty_n=%0b level=%0d head=%0d beat=%0d exp_last=%0b err=%h, expected full_n=%0b empty_n=%0b level=%0d head=%0d beat=%0d exp_last=%0b err=%h",
                 nm, a.full_n, a.empty_n, a.level, a.head_len, a.beat_cnt, a.exp_last, a.err,
                 e.full_n, e.empty_n, e.level, e.head_len, e.beat_cnt, e.exp_last, e.err);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ar_valid = 1'b0; ar_ready = 1'b0; ar_len = '0;
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; err_clr = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 0, 0), "reset0");
    step(0, 0, 0, 0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 0, 0), "reset1");

    // Basic burst of 4 beats
    step(1, 1, 0, 7, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 0, 0), "ar_no_ready");
    push(3, E(1, 1, 1, 3, 0, 0, 0), "push_len3");
    step(1, 0, 0, 0, 1, 0, 0, 0, E(1, 1, 1, 3, 0, 0, 0), "r_no_ready");
    rbeat(0, E(1, 1, 1, 3, 1, 0, 0), "beat1");
    rbeat(0, E(1, 1, 1, 3, 2, 0, 0), "beat2");
    rbeat(0, E(1, 1, 1, 3, 3, 1, 0), "beat3_exp_last");
    rbeat(1, E(1, 0, 0, 0, 0, 0, 0), "beat4_last_pop");

    // Fill to DEPTH, overflow, clear, drain
    for (int i = 0; i < 8; i++)
      push(10 + i, E((i == 7) ? 1'b0 : 1'b1, 1, i + 1, 10, 0, 0, 0), $sformatf("fill%0d", i));
    push(99, E(0, 1, 8, 10, 0, 0, 8), "push_while_full");
    step(1, 0, 0, 0, 0, 0, 0, 1, E(0, 1, 8, 10, 0, 0, 0), "err_clr");
    for (int k = 1; k <= 8; k++) begin
      int hd;
      hd = (k <= 6) ? 10 + k : ((k == 7) ? 17 : 10);
      rbeat(1, E(1, (k < 8) ? 1'b1 : 1'b0, 8 - k, hd, 0, 0, 0), $sformatf("drain%0d", k));
    end

    // Pop and push in the same cycle at level 1
    push(0, E(1, 1, 1, 0, 0, 1, 0), "push_len0");
    step(1, 1, 1, 5, 1, 1, 1, 0, E(1, 1, 1, 5, 0, 0, 0), "push_pop_same");
    rbeat(1, E(1, 0, 0, 12, 0, 0, 0), "pop_len5");

    // Beats while empty, clear priority
    rbeat(0, E(1, 0, 0, 12, 0, 0, 4), "beat_empty");
    step(1, 0, 0, 0, 0, 0, 0, 1, E(1, 0, 0, 12, 0, 0, 0), "err_clr2");
    step(1, 1, 1, 2, 1, 1, 1, 0, E(1, 1, 1, 2, 0, 0, 4), "push_beat_empty");
    step(1, 0, 0, 0, 1, 1, 0, 1, E(1, 1, 1, 2, 1, 0, 0), "clr_with_beat");
    rbeat(0, E(1, 1, 1, 2, 2, 1, 0), "beat_len2");
    rbeat(1, E(1, 0, 0, 13, 0, 0, 0), "pop_len2");
    step(1, 0, 0, 0, 1, 1, 0, 1, E(1, 0, 0, 13, 0, 0, 0), "clr_priority");
    rbeat(1, E(1, 0, 0, 13, 0, 0, 4), "beat_empty_last");

    // Reset mid-operation
    push(1, E(1, 1, 1, 1, 0, 0, 4), "pre_rst1");
    push(2, E(1, 1, 2, 1, 0, 0, 4), "pre_rst2");
    push(3, E(1, 1, 3, 1, 0, 0, 4), "pre_rst3");
    step(0, 0, 0, 0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 0, 0), "mid_reset");

`ifdef BURST_TRK_CHK_EN
    push(3, E(1, 1, 1, 3, 0, 0, 0), "chk_push3");
    rbeat(0, E(1, 1, 1, 3, 1, 0, 0), "chk_beat1");
    rbeat(1, E(1, 0, 0, 0, 0, 0, 1), "chk_early_last");
    push(1, E(1, 1, 1, 1, 0, 0, 1), "chk_push1");
    rbeat(0, E(1, 1, 1, 1, 1, 1, 1), "chk_beat1b");
    rbeat(0, E(1, 0, 0, 0, 0, 0, 3), "chk_missing_last");
`else
    push(1, E(1, 1, 1, 1, 0, 0, 0), "nochk_push1");
    rbeat(0, E(1, 1, 1, 1, 1, 1, 0), "nochk_beat1");
    rbeat(0, E(1, 1, 1, 1, 2, 0, 0), "nochk_overrun");
    rbeat(1, E(1, 0, 0, 0, 0, 0, 0), "nochk_last_pop");
`endif

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
